// File: rtl/diy8_pkg.sv
// -----------------------------------------------------------------------------
// diy8_pkg -- shared definitions for the shared-register UART transmitter.
//
// Contents:
//   DEFAULT_CLKS_PER_BIT  default bit time in clk cycles
//   LAST_DATA_BIT         index of the final data bit (bit counter wraps after it)
//   state_e               transmitter FSM states
//
// Build option:
//   SHARED_REG_UART_TX_PARITY_EN  when defined, adds the PARITY state (even
//                                 parity bit between the data bits and STOP).
// -----------------------------------------------------------------------------
package diy8_pkg;

    localparam int         DEFAULT_CLKS_PER_BIT = 16;
    localparam logic [2:0] LAST_DATA_BIT        = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd5
`ifdef SHARED_REG_UART_TX_PARITY_EN
        ,
        PARITY = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/shared_reg_uart_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick -- bit-time counter for the shared-register UART transmitter.
//
// Counts clk cycles from 0 to CLKS_PER_BIT-1 and wraps. tick is high for the
// single cycle in which the count equals CLKS_PER_BIT-1, i.e. the last cycle
// of a bit time. clear forces the count back to 0 at the next edge.
//
// Ports:
//   clk    in   clock, rising edge
//   nrst   in   asynchronous active-low reset (count = 0)
//   clear  in   restart the bit time
//   tick   out  last cycle of the current bit time
// -----------------------------------------------------------------------------
module baud_tick
    import diy8_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shared_reg_uart_tx.sv
// -----------------------------------------------------------------------------
// shared_reg_uart_tx -- reader end of a 1-byte shared register feeding an
// 8N1 (or 8E1) serial transmitter, LSB first.
//
// Ports:
//   clk          in   clock, rising edge
//   nrst         in   asynchronous active-low reset
//   en           in   1 = a new byte may be fetched (checked only in IDLE)
//   has_data     in   shared register holds a byte (checked only in IDLE)
//   rd           out  registered read strobe, one cycle per byte
//   rd_data[7:0] in   byte from the shared register, valid the cycle after rd
//   txd          out  serial line, idle high
//   busy         out  1 whenever the FSM is not IDLE
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: the writer raises has_data while it holds a byte. The reader
// answers with a one-cycle rd; the writer drops has_data and presents the
// byte on rd_data for the following cycle, where it is captured on the
// LOAD -> START edge. No other value of rd_data is ever used.
//
// Build option:
//   SHARED_REG_UART_TX_PARITY_EN  inserts an even-parity bit (11-bit frame);
//                                 otherwise the frame is 10 bits.
// -----------------------------------------------------------------------------
module shared_reg_uart_tx
    import diy8_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       has_data,
    output logic       rd,
    input  logic [7:0] rd_data,
    output logic       txd,
    output logic       busy,
    output state_e     dbg_state_o
);

    state_e     state_q;
    state_e     state_d;
    logic       rd_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    // Low for the first edge after reset release so that no fetch can start
    // before the second rising edge.
    logic       armed_q;
    logic       tick;
    logic       bit_clear;
`ifdef SHARED_REG_UART_TX_PARITY_EN
    logic       parity_q;
    logic       parity_d;
`endif

    // The bit time restarts whenever the state changes; inside DATA the
    // counter simply wraps from one bit to the next.
    assign bit_clear = (state_d != state_q);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .nrst (nrst),
        .clear(bit_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SHARED_REG_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (armed_q && en && has_data) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = START;
                shift_d = rd_data;
`ifdef SHARED_REG_UART_TX_PARITY_EN
                parity_d = ^rd_data;
`endif
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef SHARED_REG_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SHARED_REG_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
`ifdef SHARED_REG_UART_TX_PARITY_EN
            PARITY:  txd = parity_q;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            rd_q      <= 1'b0;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            armed_q   <= 1'b0;
`ifdef SHARED_REG_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rd_q      <= (state_d == FETCH);
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            armed_q   <= 1'b1;
`ifdef SHARED_REG_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign rd          = rd_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shared_reg_uart_tx.sv
module tb_shared_reg_uart_tx;
    import diy8_pkg::*;

    localparam int CPB = 4;
`ifdef SHARED_REG_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CYC = NB * CPB;
    localparam int TRMAX     = 256;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic       has_data;
    logic       rd;
    logic [7:0] rd_data;
    logic       txd;
    logic       busy;
    state_e     dbg_state;

    always #5 clk = ~clk;

    shared_reg_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .has_data   (has_data),
        .rd         (rd),
        .rd_data    (rd_data),
        .txd        (txd),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    // ---------------- shared register model (writer side) ----------------
    logic       tb_rst;
    logic       wr_en;
    logic [7:0] wr_byte;
    logic [7:0] reg_q;

    // rd_data carries junk on every cycle except the one following rd.
    always @(posedge clk) begin
        if (tb_rst) begin
            has_data <= 1'b0;
            reg_q    <= 8'h00;
            rd_data  <= 8'h00;
        end else begin
            if (rd) begin
                rd_data  <= reg_q;
                has_data <= 1'b0;
            end else begin
                rd_data  <= 8'($urandom);
            end
            if (wr_en) begin
                reg_q    <= wr_byte;
                has_data <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard / trace ----------------
    logic [7:0] exp_q[$];
    logic       tr_txd [TRMAX];
    logic       tr_rd  [TRMAX];
    logic       tr_busy[TRMAX];
    int         tr_len;
    int         n_vec;
    int         n_fail;

    // ---------------- driver tasks ----------------
    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_byte = b;
        wr_en   = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr_txd[i]  = txd;
            tr_rd[i]   = rd;
            tr_busy[i] = busy;
        end
        tr_len = n;
    endtask

    function automatic int find_txd_low(input int from);
        for (int i = (from < 0 ? 0 : from); i < tr_len; i++)
            if (tr_txd[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int find_rd(input int from);
        for (int i = from; i < tr_len; i++)
            if (tr_rd[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int find_busy(input int from);
        for (int i = from; i < tr_len; i++)
            if (tr_busy[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_rd();
        int c = 0;
        for (int i = 0; i < tr_len; i++) if (tr_rd[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_busy();
        int c = 0;
        for (int i = 0; i < tr_len; i++) if (tr_busy[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_txd_low();
        int c = 0;
        for (int i = 0; i < tr_len; i++) if (tr_txd[i] !== 1'b1) c++;
        return c;
    endfunction

    // Pops the next expected byte and compares the recorded frame starting
    // at trace index f, bit by bit, each bit held for CPB cycles.
    task automatic check_frame(input int f, input string name);
        logic [7:0]    d;
        logic [NB-1:0] eb;
        logic [CPB-1:0] got;
        logic [CPB-1:0] want;
        n_vec++;
        if (exp_q.size() == 0 || f < 0 || f + FRAME_CYC >= tr_len) begin
            n_fail++;
            $display("FAIL %s frame_present: start=%0d queued=%0d, need a start bit and an expected byte",
                     name, f, exp_q.size());
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        d        = exp_q.pop_front();
        eb       = '1;
        eb[0]    = 1'b0;
        eb[8:1]  = d;
`ifdef SHARED_REG_UART_TX_PARITY_EN
        eb[9]    = ^d;
`endif
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < CPB; k++) got[k] = tr_txd[f + b*CPB + k];
            want = {CPB{eb[b]}};
            n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s bit%0d (byte %h): txd samples %b, need %b", name, b, d, got, want);
            end
        end
        n_vec++;
        if ({tr_busy[f + FRAME_CYC - 1], tr_busy[f + FRAME_CYC]} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s frame_len: busy at end %b%b, need 10", name,
                     tr_busy[f + FRAME_CYC - 1], tr_busy[f + FRAME_CYC]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int r;
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        n_vec++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b need 1", txd); end
        n_vec++; if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b need 0", rd); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_vec++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d need IDLE", dbg_state); end
        // A byte already waiting at release must not be fetched on the first edge.
        write_byte(8'($urandom_range(0, 255)));
        nrst = 1'b1;
        record(80);
        r = find_rd(0);
        n_vec++;
        if (r < 1) begin n_fail++; $display("FAIL release_rd: first rd at trace %0d, need >= 1", r); end
        n_vec++;
        if (count_rd() !== 1) begin n_fail++; $display("FAIL release_rd_count: got %0d need 1", count_rd()); end
        check_frame(find_txd_low(0), "post_release");
    endtask

    task automatic test_basic();
        int r;
        int f;
        write_byte(8'hA5);
        record(80);
        r = find_rd(0);
        f = find_txd_low(0);
        n_vec++;
        if (count_rd() !== 1) begin n_fail++; $display("FAIL basic_rd_width: got %0d need 1", count_rd()); end
        n_vec++;
        if (r < 0 || f - r !== 2) begin n_fail++; $display("FAIL basic_rd_to_start: got %0d need 2 (rd %0d)", f - r, r); end
        n_vec++;
        if (count_busy() !== 2 + FRAME_CYC) begin
            n_fail++; $display("FAIL basic_busy_len: got %0d need %0d", count_busy(), 2 + FRAME_CYC);
        end
        n_vec++;
        if (find_busy(0) !== r) begin n_fail++; $display("FAIL basic_busy_start: got %0d need %0d", find_busy(0), r); end
        check_frame(f, "basic_a5");
    endtask

    task automatic test_back_to_back();
        int f1;
        int f2;
        write_byte(8'h00);
        fork
            record(140);
            begin
                for (int i = 0; i < 20 && has_data; i++) @(negedge clk);
                write_byte(8'hFF);
            end
        join
        n_vec++;
        if (count_rd() !== 2) begin n_fail++; $display("FAIL b2b_rd_count: got %0d need 2", count_rd()); end
        n_vec++;
        if (has_data !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: has_data %b need 0", has_data); end
        f1 = find_txd_low(0);
        check_frame(f1, "b2b_first");
        f2 = find_txd_low(f1 + FRAME_CYC);
        n_vec++;
        if (f2 - (f1 + FRAME_CYC) !== 3) begin
            n_fail++; $display("FAIL b2b_gap: got %0d idle cycles need 3", f2 - (f1 + FRAME_CYC));
        end
        check_frame(f2, "b2b_second");
    endtask

    task automatic test_en_gate();
        en = 1'b0;
        write_byte(8'($urandom_range(0, 255)));
        record(50);
        n_vec++;
        if (count_rd() !== 0) begin n_fail++; $display("FAIL en_gate_rd: got %0d pulses need 0", count_rd()); end
        n_vec++;
        if (count_txd_low() !== 0) begin n_fail++; $display("FAIL en_gate_txd: got %0d low cycles need 0", count_txd_low()); end
        en = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rd !== 1'b1) begin n_fail++; $display("FAIL en_release_rd: got %b need 1", rd); end
        record(60);
        check_frame(find_txd_low(0), "en_release");
    endtask

    task automatic test_en_midframe();
        int f;
        write_byte(8'h5A);
        fork
            record(120);
            begin
                repeat (20) @(negedge clk);
                en = 1'b0;
                for (int i = 0; i < 10 && has_data; i++) @(negedge clk);
                write_byte(8'($urandom_range(0, 255)));
            end
        join
        n_vec++;
        if (count_rd() !== 1) begin n_fail++; $display("FAIL midframe_rd_count: got %0d need 1", count_rd()); end
        f = find_txd_low(0);
        check_frame(f, "midframe_5a");
        n_vec++;
        if (f >= 0 && find_txd_low(f + FRAME_CYC) !== -1) begin
            n_fail++; $display("FAIL midframe_no_fetch: start at %0d need none", find_txd_low(f + FRAME_CYC));
        end
        en = 1'b1;
        record(60);
        check_frame(find_txd_low(0), "midframe_resume");
    endtask

    task automatic test_reset_midframe();
        int f = -1;
        write_byte(8'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin f = i; break; end
        end
        n_vec++;
        if (f < 0) begin n_fail++; $display("FAIL rstmid_start: no start bit within 20 cycles, need one"); end
        // Start cycle 0 was just sampled; 17 more cycles lands in data bit 3.
        repeat (CPB*4 + 1) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b need 1", busy); end
        #2 nrst = 1'b0;
        #1;
        n_vec++; if (txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd: got %b need 1", txd); end
        n_vec++; if (rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd: got %b need 0", rd); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b need 0", busy); end
        n_vec++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d need IDLE", dbg_state); end
        // The in-flight byte is lost by design.
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        record(80);
        n_vec++;
        if (count_rd() !== 0) begin n_fail++; $display("FAIL rstmid_reissue: got %0d rd pulses need 0", count_rd()); end
        n_vec++;
        if (count_txd_low() !== 0) begin n_fail++; $display("FAIL rstmid_line: got %0d low cycles need 0", count_txd_low()); end
    endtask

`ifdef SHARED_REG_UART_TX_PARITY_EN
    task automatic test_parity();
        write_byte(8'h07);
        record(80);
        check_frame(find_txd_low(0), "parity_07");
        write_byte(8'h03);
        record(80);
        check_frame(find_txd_low(0), "parity_03");
    endtask
`endif

    // ---------------- main sequence and report ----------------
    initial begin
        n_vec   = 0;
        n_fail  = 0;
        nrst    = 1'b0;
        en      = 1'b1;
        tb_rst  = 1'b1;
        wr_en   = 1'b0;
        wr_byte = 8'h00;
        tr_len  = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_en_gate();
        test_en_midframe();
        test_reset_midframe();
`ifdef SHARED_REG_UART_TX_PARITY_EN
        test_parity();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: %0d bytes never seen, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
